// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states
// and iteration count.
package mips_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/data bundle between the register-file side of the datapath and the
// multiply/divide unit.
interface mult_div_unit_if;

  logic                       start;
  logic [1:0]                 op;
  logic [mips_pkg::WIDTH-1:0] src_a;
  logic [mips_pkg::WIDTH-1:0] src_b;
  logic                       mthi;
  logic                       mtlo;
  logic [mips_pkg::WIDTH-1:0] hi;
  logic [mips_pkg::WIDTH-1:0] lo;
  logic                       busy;
  logic                       done;
  logic                       div_by_zero;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply / restoring divide with HI/LO registers. Operands are
// processed as magnitudes and the signs are applied in a single FIX cycle.
module mult_div_unit
  import mips_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  state_e               state_q;
  logic [5:0]           cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 start_div;
  logic                 start_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  always_comb begin
    start_div    = bus.op[1];
    start_signed = ~bus.op[0];
    mag_a = (start_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    mag_b = (start_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  end

  // Shared adder: multiply adds the multiplicand to the upper half, divide
  // subtracts the divisor from the shifted remainder (bit 33 = borrow).
  logic [WIDTH+1:0]     add_a;
  logic [WIDTH+1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH+1:0]     sum;
  logic [WIDTH:0]       mul_upper;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    if (is_div_q) begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
      add_b   = ~{2'b00, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = {2'b00, opnd_q};
      add_cin = 1'b0;
    end
    sum       = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
    mul_upper = acc_q[0] ? sum[WIDTH:0] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (is_div_q) begin
      acc_step = sum[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                              : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_upper, acc_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // With a zero divisor every step subtracts nothing, so the remainder ends up
  // as the dividend magnitude and re-signing it reproduces the original src_a.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            is_div_q  <= start_div;
            neg_res_q <= start_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_rem_q <= start_signed && bus.src_a[WIDTH-1];
            dz_q      <= start_div && (bus.src_b == '0);
            opnd_q    <= start_div ? mag_b : mag_a;
            acc_q     <= {{WIDTH{1'b0}}, start_div ? mag_a : mag_b};
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.src_a;
            if (bus.mtlo) lo_q <= bus.src_a;
          end
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITER_COUNT - 1)) state_q <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            hi_q  <= rem_fix;
            lo_q  <= dz_q ? {WIDTH{1'b1}} : quo_fix;
            dbz_q <= dz_q;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      2'b01: begin
        p = ua * ub;
        return {1'b0, p};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        p = 64'(sa % sb);
        ua = 64'(sa / sb);
        return {1'b0, p[31:0], ua[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        p = ua % ub;
        ua = ua / ub;
        return {1'b0, p[31:0], ua[31:0]};
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Called #1 after an edge with the unit idle; returns #1 after the done edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [64:0] m;
    m = model(op, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk); #1;
    for (int i = 0; i <= 32; i++) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      check({tag, "_hold_hi"}, bus.hi, exp_hi);
      check({tag, "_hold_lo"}, bus.lo, exp_lo);
      if (i < 32) begin
        bus.start = 1'($urandom);
        bus.op    = 2'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.mthi  = 1'($urandom);
        bus.mtlo  = 1'($urandom);
      end else begin
        idle_inputs();
      end
      @(posedge clk); #1;
    end
    exp_hi = m[63:32];
    exp_lo = m[31:0];
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(m[64]));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_fail   = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    bus.mthi  = 1'b1;
    bus.src_a = 32'hAAAA_5555;
    @(posedge clk); #1;
    idle_inputs();
    exp_hi = 32'hAAAA_5555;
    check("mthi_hi", bus.hi, exp_hi);
    check("mthi_lo", bus.lo, exp_lo);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.src_a = 32'h1357_9BDF;
    @(posedge clk); #1;
    idle_inputs();
    exp_hi = 32'h1357_9BDF;
    exp_lo = 32'h1357_9BDF;
    check("mthilo_hi", bus.hi, exp_hi);
    check("mthilo_lo", bus.lo, exp_lo);

    run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD);
    check("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_lit", bus.lo, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_lit", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo_lit", bus.lo, 32'h0000_0001);

    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_lit", bus.lo, 32'hFFFF_FFFD);
    check("div_hi_lit", bus.hi, 32'hFFFF_FFFF);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    check("divu_lo_lit", bus.lo, 32'd14);
    check("divu_hi_lit", bus.hi, 32'd2);

    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0);
    check("divu0_lo_lit", bus.lo, 32'hFFFF_FFFF);
    check("divu0_hi_lit", bus.hi, 32'h0000_1234);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo_lit", bus.lo, 32'h8000_0000);
    check("ovf_hi_lit", bus.hi, 32'd0);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op("div_minint_by0", 2'b10, 32'h8000_0000, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 28);
      run_op("rand", rop, ra, rb);
      if (k[0]) begin
        @(posedge clk); #1;
      end
    end

    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.src_a = 32'h0001_0003;
    bus.src_b = 32'h0007_0005;
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu_3_5", 2'b01, 32'd3, 32'd5);
    check("multu35_lo_lit", bus.lo, 32'd15);
    check("multu35_hi_lit", bus.hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: consumes its two read ports (rs, rt) on MULT/MULTU/DIV/DIVU, runs a 32-iteration shift-add or restoring-divide sequence, and holds the 64-bit result in HI/LO. MFHI/MFLO results are fed back to the register file's write-data mux. While busy, the unit raises a stall request to the control path.

## Interface

- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  input  1  rising-edge clock, shared with the register file.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src_a  input  WIDTH  rs value (register file readData1); multiplicand or dividend.
- src_b  input  WIDTH  rt value (register file readData2); multiplier or divisor.
- mthi  input  1  write src_a into HI; honoured only in IDLE without start.
- mtlo  input  1  write src_a into LO; same rule as mthi.
- hi  output  WIDTH  HI register; reset 0.
- lo  output  WIDTH  LO register; reset 0.
- busy  output  1  operation in progress (stall request); reset 0.
- done  output  1  one-cycle pulse when HI/LO are updated; reset 0.
- div_by_zero  output  1  valid with done; 1 if a DIV/DIVU had src_b == 0; reset 0.

## Operation

- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1: latch operand magnitudes (absolute value for signed ops, raw for unsigned), result-sign and remainder-sign flags, and op; clear the 6-bit iteration counter; go to RUN.
  - start=0: mthi/mtlo update HI/LO. If both are set, both update.
- RUN: one iteration per cycle, counter 0..31.
  - Multiply: 64-bit product/multiplier shift register; add the multiplicand to the upper half when the LSB is 1, then shift right.
  - Divide: restoring division; shift the remainder left, bringing in the next dividend bit; subtract the divisor when the remainder is at least the divisor and set the quotient bit.
  - After iteration 31, go to FIX.
- FIX: apply signs and commit, then return to IDLE.
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
  - Write HI = upper product / remainder and LO = lower product / quotient.
  - Assert done for one cycle.
- Divide by zero: HI = src_a (original, unsigned or signed), LO = all ones, div_by_zero=1. The iteration still takes the full latency.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0, no flag.
- HI/LO keep their old values for the whole of RUN; they change only in FIX or through mthi/mtlo.
- start, mthi and mtlo are ignored while busy. The operand inputs are not needed after the start edge.
- Asynchronous reset at any point (including mid-RUN): IDLE, all outputs 0, internal registers 0.

## Timing

- Start accepted on edge E0. busy=1 after E0.
- RUN iterations occur on E1..E32. FIX occurs on E33.
- After E33: HI/LO are valid, done=1 and busy=0 for that one cycle.
- Latency from start to done is 33 cycles.
- A new start is accepted on the edge that ends the done cycle, giving back-to-back operations with one IDLE cycle.
- Outputs hi and lo are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package mips_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, RUN, FIX;
  - ITER_COUNT = 32.
- Single module; no sub-module. The add/subtract datapath is shared between multiply and divide.

## Test plan

- MULT, src_a=7, src_b=0xFFFFFFFD (-3) -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once; busy high for exactly 33 cycles.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100/7 issued back to back -> lo=14, hi=2.
- DIVU, src_a=0x1234, src_b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1 with done. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi with src_a=0xAAAA5555 in IDLE -> hi=0xAAAA5555 next cycle. During a RUN: mtlo, start and op changes are ignored, and HI/LO stay unchanged until FIX.
- Assert rst_n low at RUN iteration 10 -> busy, done, hi and lo are 0 immediately. After release, a MULTU 3×5 gives lo=15, hi=0 at the normal latency.
